mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the BUSY-cycle limit before a bus timeout is raised.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  SHALL be asynchronous and active-low (0 = reset).
REQ-004 flush_in, stall_in  in  1 each  hazard-unit flush and hold of the E->C register.
REQ-005 alu_res_in, write_data_in, pc_plus4_in  in  XLEN each  address or ALU result, store data, PC+4.
REQ-006 rd_in  in  REG_BITS;  reg_write_in, mem_write_in  in  1;  result_src_in  in  result_src_e;  data_size_in  in  data_size_e;  xcpt_in  in  xcpt_e.
REQ-007 alu_res_out, pc_plus4_out  out  XLEN  registered values; alu_res_out is the C-stage forwarding source.
REQ-008 rd_out  out  REG_BITS;  reg_write_out  out  1;  result_src_out  out  result_src_e;  xcpt_out  out  xcpt_e.
REQ-009 read_data_out  out  XLEN  load data, already extended.
REQ-010 stall_out  out  1  memory access incomplete; the hazard unit freezes upstream stages.
REQ-011 mem_req_out, mem_we_out  out  1;  mem_addr_out, mem_wdata_out  out  XLEN;  mem_be_out  out  4  bus request.
REQ-012 mem_ack_in  in  1;  mem_rdata_in  in  XLEN  bus completion and read data.

Function
REQ-013 Advance: the E->C register SHALL load its inputs when stall_in=0 and stall_out=0.
REQ-014 Clear: the E->C register SHALL clear when flush_in=1 and stall_out=0; a hold has no effect on a flush.
REQ-015 Access condition: an access exists when (mem_write_out | result_src_out==FROM_CACHE) and xcpt_in (registered) == NO_XCPT.
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE -> BUSY when an access exists; IDLE -> IDLE otherwise.
REQ-018 BUSY -> DONE on mem_ack_in=1, or when the timeout counter reaches TIMEOUT_CYCLES.
REQ-019 DONE -> IDLE when stall_in=0; DONE holds otherwise.
REQ-020 mem_req_out SHALL be 1 only in BUSY; mem_ack_in SHALL be ignored outside BUSY.
REQ-021 stall_out SHALL equal (IDLE & access exists) | BUSY; minimum access occupancy is 3 cycles (IDLE, BUSY with ack, DONE).
REQ-022 Byte enables: W -> 4'b1111; B -> 4'b0001 << addr[1:0]. mem_wdata_out SHALL be write_data for W and the low byte replicated x4 for B.
REQ-023 mem_addr_out SHALL equal alu_res_out; mem_we_out SHALL equal mem_write_out.
REQ-024 Load data SHALL be captured on the ack cycle: W -> mem_rdata_in; B -> the byte at addr[1:0], sign-extended.
REQ-025 Timeout: an 8-bit-or-wider counter SHALL count BUSY cycles, reset on BUSY entry; at TIMEOUT_CYCLES, mem_req_out drops, xcpt_out=BUS_TIMEOUT, reg_write_out=0.
REQ-026 Exception passthrough: xcpt_in != NO_XCPT SHALL issue no bus request, pass xcpt_out unchanged, and force reg_write_out=0.
REQ-027 Flush while stall_out=1: a sticky kill bit SHALL be set; the bus transaction completes normally (req held until ack or timeout).
REQ-028 On kill: the instruction SHALL retire with reg_write_out=0 and xcpt_out=NO_XCPT, then the register clears; kill clears on DONE->IDLE.

Reset
REQ-029 On reset=0, all registers, read_data_out, the counter and kill SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-030 Reset mid-transaction SHALL drop mem_req_out immediately; an ack arriving later SHALL be ignored.

Structure
REQ-031 BUS_TIMEOUT SHALL be added to xcpt_e, and mem_state_e to brisc_pkg; XLEN, REG_BITS, data_size_e and result_src_e are reused from it.
REQ-032 Byte-lane steering and extension SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-033 SW, addr 0x1004, data 0xDEADBEEF, ack on 2nd BUSY cycle -> be=1111, wdata=0xDEADBEEF, stall_out high for 3 cycles.
REQ-034 LB, addr 0x1003, rdata 0x80FF_0000 -> be=1000, read_data_out=0xFFFFFF80.
REQ-035 LW with xcpt_in=MEM_UNALIGNED -> mem_req_out never 1, xcpt_out=MEM_UNALIGNED, reg_write_out=0.
REQ-036 LW, no ack, TIMEOUT_CYCLES=4 -> req high for 4 cycles, then xcpt_out=BUS_TIMEOUT and stall_out=0.
REQ-037 flush_in pulsed during BUSY of LW, ack 3 cycles later -> req held until ack, then reg_write_out=0 and xcpt_out=NO_XCPT.
REQ-038 reset=0 asserted during BUSY -> mem_req_out=0 asynchronously and FSM=IDLE; a subsequent ack causes no state change.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared types for the brisc pipeline: widths, pipeline enums and the
// execute->cache pipeline register payload.
package brisc_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_BITS = 5;

    typedef enum logic [1:0] {
        FROM_ALU   = 2'd0,
        FROM_CACHE = 2'd1,
        FROM_PC4   = 2'd2
    } result_src_e;

    typedef enum logic {
        SIZE_B = 1'b0,
        SIZE_W = 1'b1
    } data_size_e;

    typedef enum logic [1:0] {
        NO_XCPT       = 2'd0,
        MEM_UNALIGNED = 2'd1,
        ILLEGAL_INSTR = 2'd2,
        BUS_TIMEOUT   = 2'd3
    } xcpt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Execute->cache pipeline register contents
    typedef struct packed {
        logic [XLEN-1:0]     alu_res;
        logic [XLEN-1:0]     write_data;
        logic [XLEN-1:0]     pc_plus4;
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
        logic                mem_write;
        result_src_e         result_src;
        data_size_e          data_size;
        xcpt_e               xcpt;
    } ec_reg_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane select plus sign extension for loads.
module mem_lane_align
    import brisc_pkg::*;
(
    input  logic [1:0]      offset,
    input  data_size_e      size,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] rdata_c
);

    logic [7:0] byte_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        rdata_c = rdata;
        if (size == SIZE_B) begin
            be_c    = 4'b0001 << offset;
            wdata_c = {4{wdata[7:0]}};
            rdata_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Cache/memory pipeline stage: E->C register, single-outstanding bus access
// FSM with timeout, flush-kill handling and load-data capture.
module mem_access_stage
    import brisc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_in,
    input  logic                stall_in,
    input  logic [XLEN-1:0]     alu_res_in,
    input  logic [XLEN-1:0]     write_data_in,
    input  logic [XLEN-1:0]     pc_plus4_in,
    input  logic [REG_BITS-1:0] rd_in,
    input  logic                reg_write_in,
    input  logic                mem_write_in,
    input  result_src_e         result_src_in,
    input  data_size_e          data_size_in,
    input  xcpt_e               xcpt_in,
    output logic [XLEN-1:0]     alu_res_out,
    output logic [XLEN-1:0]     pc_plus4_out,
    output logic [REG_BITS-1:0] rd_out,
    output logic                reg_write_out,
    output result_src_e         result_src_out,
    output xcpt_e               xcpt_out,
    output logic [XLEN-1:0]     read_data_out,
    output logic                stall_out,
    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic [XLEN-1:0]     mem_addr_out,
    output logic [XLEN-1:0]     mem_wdata_out,
    output logic [3:0]          mem_be_out,
    input  logic                mem_ack_in,
    input  logic [XLEN-1:0]     mem_rdata_in
);

    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ec_reg_t         ec_q;
    ec_reg_t         ec_load_c;
    mem_state_e      state_q;
    mem_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic            kill_q;
    logic            access_c;
    logic            ack_c;
    logic            timeout_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] rdata_c;

    assign access_c = (ec_q.mem_write || (ec_q.result_src == FROM_CACHE))
                      && (ec_q.xcpt == NO_XCPT);

    // Faulting instructions never write back
    always_comb begin
        ec_load_c            = '0;
        ec_load_c.alu_res    = alu_res_in;
        ec_load_c.write_data = write_data_in;
        ec_load_c.pc_plus4   = pc_plus4_in;
        ec_load_c.rd         = rd_in;
        ec_load_c.reg_write  = reg_write_in && (xcpt_in == NO_XCPT);
        ec_load_c.mem_write  = mem_write_in;
        ec_load_c.result_src = result_src_in;
        ec_load_c.data_size  = data_size_in;
        ec_load_c.xcpt       = xcpt_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        stall_out   = 1'b0;
        mem_req_out = 1'b0;
        ack_c       = 1'b0;
        timeout_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_c) begin
                    state_d   = BUSY;
                    stall_out = 1'b1;
                end
            end
            BUSY: begin
                stall_out   = 1'b1;
                mem_req_out = 1'b1;
                ack_c       = mem_ack_in;
                timeout_c   = !mem_ack_in && (cnt_q == CNT_LAST);
                if (ack_c || timeout_c) state_d = DONE;
            end
            DONE: begin
                if (!stall_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush during an access only kills write-back; the bus cycle still completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ec_q          <= '0;
            kill_q        <= 1'b0;
            cnt_q         <= '0;
            read_data_out <= '0;
        end else begin
            if (!stall_out && (flush_in || kill_q)) begin
                ec_q <= '0;
            end else if (!stall_out && !stall_in) begin
                ec_q <= ec_load_c;
            end else begin
                if (flush_in) ec_q.reg_write <= 1'b0;
                if (timeout_c && !flush_in && !kill_q) begin
                    ec_q.xcpt      <= BUS_TIMEOUT;
                    ec_q.reg_write <= 1'b0;
                end
            end

            if (flush_in && stall_out)               kill_q <= 1'b1;
            else if ((state_q == DONE) && !stall_in) kill_q <= 1'b0;

            cnt_q <= (state_q == BUSY) ? cnt_q + CNT_W'(1) : '0;

            if (ack_c && (ec_q.result_src == FROM_CACHE)) read_data_out <= rdata_c;
        end
    end

    mem_lane_align u_align (
        .offset  (ec_q.alu_res[1:0]),
        .size    (ec_q.data_size),
        .wdata   (ec_q.write_data),
        .rdata   (mem_rdata_in),
        .be_c    (be_c),
        .wdata_c (wdata_c),
        .rdata_c (rdata_c)
    );

    assign alu_res_out    = ec_q.alu_res;
    assign pc_plus4_out   = ec_q.pc_plus4;
    assign rd_out         = ec_q.rd;
    assign reg_write_out  = ec_q.reg_write;
    assign result_src_out = ec_q.result_src;
    assign xcpt_out       = ec_q.xcpt;
    assign mem_we_out     = ec_q.mem_write;
    assign mem_addr_out   = ec_q.alu_res;
    assign mem_wdata_out  = wdata_c;
    assign mem_be_out     = be_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected bus handshakes and
// retirements are queued by the stimulus and checked by a negedge monitor.
module tb_mem_access_stage;
    import brisc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_in, stall_in;
    logic [31:0] alu_res_in, write_data_in, pc_plus4_in;
    logic [4:0]  rd_in;
    logic        reg_write_in, mem_write_in;
    result_src_e result_src_in;
    data_size_e  data_size_in;
    xcpt_e       xcpt_in;
    logic [31:0] alu_res_out, pc_plus4_out, read_data_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    result_src_e result_src_out;
    xcpt_e       xcpt_out;
    logic        stall_out, mem_req_out, mem_we_out;
    logic [31:0] mem_addr_out, mem_wdata_out;
    logic [3:0]  mem_be_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in), .stall_in(stall_in),
        .alu_res_in(alu_res_in), .write_data_in(write_data_in), .pc_plus4_in(pc_plus4_in),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_write_in(mem_write_in),
        .result_src_in(result_src_in), .data_size_in(data_size_in), .xcpt_in(xcpt_in),
        .alu_res_out(alu_res_out), .pc_plus4_out(pc_plus4_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .result_src_out(result_src_out), .xcpt_out(xcpt_out),
        .read_data_out(read_data_out), .stall_out(stall_out), .mem_req_out(mem_req_out),
        .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_be_out(mem_be_out), .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_exp_t;

    typedef struct {
        logic        rw;
        xcpt_e       x;
        logic        chk_rd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          req;
        int          stl;
    } ret_exp_t;

    bus_exp_t bus_q[$];
    ret_exp_t ret_q[$];
    int checks = 0;
    int errors = 0;
    logic prev_stall = 1'b0;
    int req_cnt = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, wdata, input logic [3:0] be);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
        bus_q.push_back(e);
    endtask

    task automatic push_ret(input logic rw, input xcpt_e x, input logic chk_rd,
                            input logic [31:0] rdata, input logic [4:0] rd, input int req, stl);
        ret_exp_t e;
        e.rw = rw; e.x = x; e.chk_rd = chk_rd; e.rdata = rdata; e.rd = rd; e.req = req; e.stl = stl;
        ret_q.push_back(e);
    endtask

    // Monitor: compares bus handshakes and retirements (falling edge of stall_out)
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            req_cnt    = 0;
            stall_cnt  = 0;
        end else begin
            if (mem_req_out) req_cnt++;
            if (stall_out) stall_cnt++;
            if (mem_req_out && mem_ack_in) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    bus_exp_t b;
                    b = bus_q.pop_front();
                    chk("bus_we", 32'(mem_we_out), 32'(b.we));
                    chk("bus_addr", mem_addr_out, b.addr);
                    chk("bus_be", 32'(mem_be_out), 32'(b.be));
                    if (b.we) chk("bus_wdata", mem_wdata_out, b.wdata);
                end
            end
            if (!stall_out && prev_stall) begin
                if (ret_q.size() == 0) begin
                    chk("ret_unexpected", 32'd1, 32'd0);
                end else begin
                    ret_exp_t r;
                    r = ret_q.pop_front();
                    chk("ret_reg_write", 32'(reg_write_out), 32'(r.rw));
                    chk("ret_xcpt", 32'(xcpt_out), 32'(r.x));
                    chk("ret_rd", 32'(rd_out), 32'(r.rd));
                    chk("ret_req_cycles", 32'(req_cnt), 32'(r.req));
                    chk("ret_stall_cycles", 32'(stall_cnt), 32'(r.stl));
                    if (r.chk_rd) chk("ret_read_data", read_data_out, r.rdata);
                end
                req_cnt   = 0;
                stall_cnt = 0;
            end
            prev_stall = stall_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] alu, wd, input logic [4:0] rd, input logic rw, mw,
                             input result_src_e rs, input data_size_e ds, input xcpt_e x);
        alu_res_in    = alu;
        write_data_in = wd;
        pc_plus4_in   = alu ^ 32'h0000_0F00;
        rd_in         = rd;
        reg_write_in  = rw;
        mem_write_in  = mw;
        result_src_in = rs;
        data_size_in  = ds;
        xcpt_in       = x;
    endtask

    task automatic bubble();
        set_instr(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, FROM_ALU, SIZE_W, NO_XCPT);
        flush_in = 1'b0;
    endtask

    // Issue one memory op; ack in BUSY cycle ack_at (0 = never), run `cycles` BUSY-side cycles
    task automatic run_mem(input logic [31:0] addr, wd, rdata, input logic [4:0] rd,
                           input logic rw, mw, input result_src_e rs, input data_size_e ds,
                           input int ack_at, input int cycles);
        set_instr(addr, wd, rd, rw, mw, rs, ds, NO_XCPT);
        step();
        bubble();
        for (int c = 1; c <= cycles; c++) begin
            step();
            mem_ack_in   = (c == ack_at);
            mem_rdata_in = rdata;
        end
        step();
        mem_ack_in = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        reset        = 1'b0;
        stall_in     = 1'b0;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        bubble();
        repeat (2) step();
        @(negedge clk);
        chk("rst_reg_write", 32'(reg_write_out), 32'd0);
        chk("rst_xcpt", 32'(xcpt_out), 32'd0);
        chk("rst_read_data", read_data_out, 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_req", 32'(mem_req_out), 32'd0);
        chk("rst_alu_res", alu_res_out, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Plain ALU advance, hold under stall_in, flush overriding hold
        set_instr(32'hCAFE_0001, 32'h0, 5'd3, 1'b1, 1'b0, FROM_ALU, SIZE_W, NO_XCPT);
        step();
        @(negedge clk);
        chk("alu_res", alu_res_out, 32'hCAFE_0001);
        chk("alu_pc4", pc_plus4_out, 32'hCAFE_0F01);
        chk("alu_rd", 32'(rd_out), 32'd3);
        chk("alu_reg_write", 32'(reg_write_out), 32'd1);
        chk("alu_no_stall", 32'(stall_out), 32'd0);
        step();
        stall_in = 1'b1;
        set_instr(32'h0000_0BAD, 32'h0, 5'd4, 1'b1, 1'b0, FROM_ALU, SIZE_W, NO_XCPT);
        step();
        @(negedge clk);
        chk("hold_alu_res", alu_res_out, 32'hCAFE_0001);
        step();
        flush_in = 1'b1;
        step();
        @(negedge clk);
        chk("flush_rd", 32'(rd_out), 32'd0);
        chk("flush_reg_write", 32'(reg_write_out), 32'd0);
        step();
        stall_in = 1'b0;
        bubble();
        step();

        // SW word, ack on 2nd BUSY cycle
        push_bus(1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b1111);
        push_ret(1'b0, NO_XCPT, 1'b0, 32'h0, 5'd0, 2, 3);
        run_mem(32'h1004, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b1, FROM_ALU, SIZE_W, 2, 2);

        // LB from top lane, negative byte
        push_bus(1'b0, 32'h1003, 32'h0, 4'b1000);
        push_ret(1'b1, NO_XCPT, 1'b1, 32'hFFFF_FF80, 5'd5, 1, 2);
        run_mem(32'h1003, 32'h0, 32'h80FF_0000, 5'd5, 1'b1, 1'b0, FROM_CACHE, SIZE_B, 1, 1);

        // LW with ack on the very cycle the timeout would fire: ack wins
        push_bus(1'b0, 32'h2000, 32'h0, 4'b1111);
        push_ret(1'b1, NO_XCPT, 1'b1, 32'h1234_5678, 5'd7, 4, 5);
        run_mem(32'h2000, 32'h0, 32'h1234_5678, 5'd7, 1'b1, 1'b0, FROM_CACHE, SIZE_W, 4, 4);

        // SB replicates the low byte, lane 2
        push_bus(1'b1, 32'h1002, 32'hA5A5_A5A5, 4'b0100);
        push_ret(1'b0, NO_XCPT, 1'b0, 32'h0, 5'd0, 1, 2);
        run_mem(32'h1002, 32'h1234_56A5, 32'h0, 5'd0, 1'b0, 1'b1, FROM_ALU, SIZE_B, 1, 1);

        // LB lane 1, positive byte
        push_bus(1'b0, 32'h1001, 32'h0, 4'b0010);
        push_ret(1'b1, NO_XCPT, 1'b1, 32'h0000_007F, 5'd12, 3, 4);
        run_mem(32'h1001, 32'h0, 32'hAA00_7F55, 5'd12, 1'b1, 1'b0, FROM_CACHE, SIZE_B, 3, 3);

        // LW with no ack: timeout after 4 BUSY cycles
        push_ret(1'b0, BUS_TIMEOUT, 1'b0, 32'h0, 5'd8, 4, 5);
        run_mem(32'h2004, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, FROM_CACHE, SIZE_W, 0, 6);

        // LW arriving with an exception: no bus access, exception passes through
        set_instr(32'h2001, 32'h0, 5'd4, 1'b1, 1'b0, FROM_CACHE, SIZE_W, MEM_UNALIGNED);
        step();
        stall_in = 1'b1;
        bubble();
        reqs = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_req_out) reqs++;
            if (c == 0) begin
                chk("xcpt_pass", 32'(xcpt_out), 32'(MEM_UNALIGNED));
                chk("xcpt_reg_write", 32'(reg_write_out), 32'd0);
                chk("xcpt_no_stall", 32'(stall_out), 32'd0);
            end
            step();
        end
        chk("xcpt_req_cycles", 32'(reqs), 32'd0);
        stall_in = 1'b0;
        step();

        // Flush during BUSY: bus completes, write-back killed, register then clears
        push_bus(1'b0, 32'h3000, 32'h0, 4'b1111);
        push_ret(1'b0, NO_XCPT, 1'b0, 32'h0, 5'd9, 4, 5);
        set_instr(32'h3000, 32'h0, 5'd9, 1'b1, 1'b0, FROM_CACHE, SIZE_W, NO_XCPT);
        step();
        set_instr(32'h0000_0077, 32'h0, 5'd3, 1'b1, 1'b0, FROM_ALU, SIZE_W, NO_XCPT);
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        step();
        step();
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'hFFFF_FFFF;
        step();
        mem_ack_in = 1'b0;
        step();
        @(negedge clk);
        chk("kill_cleared_rd", 32'(rd_out), 32'd0);
        chk("kill_cleared_rw", 32'(reg_write_out), 32'd0);
        step();
        @(negedge clk);
        chk("after_kill_rd", 32'(rd_out), 32'd3);
        step();
        bubble();
        repeat (2) step();

        // Asynchronous reset during BUSY; later ack ignored
        set_instr(32'h2008, 32'h0, 5'd6, 1'b1, 1'b0, FROM_CACHE, SIZE_W, NO_XCPT);
        step();
        bubble();
        step();
        chk("pre_reset_req", 32'(mem_req_out), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_req", 32'(mem_req_out), 32'd0);
        chk("async_reset_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #2;
        reset        = 1'b1;
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'hAAAA_5555;
        @(negedge clk);
        chk("late_ack_req", 32'(mem_req_out), 32'd0);
        chk("late_ack_stall", 32'(stall_out), 32'd0);
        step();
        mem_ack_in = 1'b0;
        @(negedge clk);
        chk("late_ack_read_data", read_data_out, 32'd0);
        chk("late_ack_req2", 32'(mem_req_out), 32'd0);
        repeat (2) step();

        chk("bus_queue_left", 32'(bus_q.size()), 32'd0);
        chk("ret_queue_left", 32'(ret_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
